// File: rtl/fixed_activation_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fixed_activation_arbiter
// Purpose  : Time-shares one streaming fixed-point activation unit between
//            NUM_REQ requester streams. A requester is granted the unit for a
//            whole tensor burst of BEATS beats (round-robin arbitration). Each
//            accepted beat is tagged with its requester in an in-order tag
//            FIFO so results returning from the unit are steered back to the
//            requester that produced the input.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   req_data_in    in   per-requester input beats, requester r in slice r
//   req_valid      in   per-requester input valid
//   req_ready      out  per-requester input ready (only the granted one)
//   act_data_in    out  beat forwarded to the activation unit
//   act_valid      out  valid to the activation unit
//   act_ready      in   ready from the activation unit
//   act_data_out   in   result from the activation unit
//   act_out_valid  in   result valid from the activation unit
//   act_out_ready  out  result ready to the activation unit
//   resp_data_out  out  result broadcast to all requesters
//   resp_valid     out  one-hot result valid (owner of the oldest tag)
//   resp_ready     in   per-requester result ready
//   busy           out  high while bursting or while results are in flight
// ============================================================================
module fixed_activation_arbiter #(
    parameter int NUM_REQ                = 4,
    parameter int DATA_IN_0_PRECISION_0  = 16,
    parameter int DATA_OUT_0_PRECISION_0 = 18,
    parameter int PARALLELISM            = 1,
    parameter int BEATS                  = 8,
    parameter int TAG_DEPTH              = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [NUM_REQ*PARALLELISM*DATA_IN_0_PRECISION_0-1:0]  req_data_in,
    input  logic [NUM_REQ-1:0]                                    req_valid,
    output logic [NUM_REQ-1:0]                                    req_ready,
    output logic [PARALLELISM*DATA_IN_0_PRECISION_0-1:0]          act_data_in,
    output logic                                                  act_valid,
    input  logic                                                  act_ready,
    input  logic [PARALLELISM*DATA_OUT_0_PRECISION_0-1:0]         act_data_out,
    input  logic                                                  act_out_valid,
    output logic                                                  act_out_ready,
    output logic [PARALLELISM*DATA_OUT_0_PRECISION_0-1:0]         resp_data_out,
    output logic [NUM_REQ-1:0]                                    resp_valid,
    input  logic [NUM_REQ-1:0]                                    resp_ready,
    output logic                                                  busy
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_IN_W  = PARALLELISM * DATA_IN_0_PRECISION_0;
    localparam int c_TAG_W = (NUM_REQ > 1)   ? $clog2(NUM_REQ)   : 1;
    localparam int c_PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int c_CNT_W = (BEATS > 1)     ? $clog2(BEATS)     : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(BEATS - 1);
    localparam logic [c_TAG_W-1:0] c_LAST_REQ  = c_TAG_W'(NUM_REQ - 1);
    localparam logic [c_TAG_W:0]   c_NUM_REQ_W = (c_TAG_W + 1)'(NUM_REQ);
    localparam logic [c_PTR_W:0]   c_PTR_ONE   = (c_PTR_W + 1)'(1);

    // FSM encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [c_TAG_W-1:0] r_grant;
    logic [c_TAG_W-1:0] r_rr_ptr;
    logic [c_CNT_W-1:0] r_beat_cnt;

    // Tag FIFO: pointers carry one extra MSB so full and empty are distinct.
    logic [c_TAG_W-1:0] r_tag_mem [TAG_DEPTH];
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [0:0]         w_state_nxt;
    logic [c_TAG_W-1:0] w_grant_nxt;
    logic [c_TAG_W-1:0] w_rr_ptr_nxt;
    logic [c_CNT_W-1:0] w_beat_cnt_nxt;
    logic [c_TAG_W-1:0] w_grant_inc;

    logic               w_arb_found;
    logic [c_TAG_W-1:0] w_arb_idx;
    logic [c_TAG_W:0]   w_arb_sum;

    logic [c_IN_W-1:0]  w_sel_data;
    logic               w_sel_valid;

    logic               w_in_burst;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [c_TAG_W-1:0] w_tag_head;
    logic               w_head_ready;
    logic               w_push;
    logic               w_pop;

    // ------------------------------------------------------------------------
    // Round-robin search: first requesting index at or above r_rr_ptr,
    // wrapping modulo NUM_REQ. Offsets are scanned from the farthest to the
    // nearest so the last hit (the nearest offset) is the one kept.
    // ------------------------------------------------------------------------
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_arb_sum   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_arb_sum = {1'b0, r_rr_ptr} + (c_TAG_W + 1)'(i);
            if (w_arb_sum >= c_NUM_REQ_W) begin
                w_arb_sum = w_arb_sum - c_NUM_REQ_W;
            end
            if (req_valid[w_arb_sum[c_TAG_W-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_arb_sum[c_TAG_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Granted requester selection
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (r_grant == c_TAG_W'(r)) begin
                w_sel_data  = req_data_in[r*c_IN_W +: c_IN_W];
                w_sel_valid = req_valid[r];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tag FIFO status
    // ------------------------------------------------------------------------
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                          (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_tag_head   = r_tag_mem[r_rd_ptr[c_PTR_W-1:0]];

    // ------------------------------------------------------------------------
    // Forward path. act_valid is gated by a full tag FIFO so every beat the
    // unit accepts is guaranteed a tag slot.
    // ------------------------------------------------------------------------
    assign w_in_burst  = (r_state == c_ST_BURST);
    assign act_valid   = w_in_burst && w_sel_valid && !w_fifo_full;
    assign act_data_in = w_in_burst ? w_sel_data : '0;
    assign w_push      = act_valid && act_ready;

    always_comb begin
        req_ready = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_in_burst && act_ready && !w_fifo_full && (r_grant == c_TAG_W'(r))) begin
                req_ready[r] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Return path: results come back in acceptance order, so the FIFO head
    // names the owner of the result currently offered by the unit.
    // ------------------------------------------------------------------------
    always_comb begin
        resp_valid   = '0;
        w_head_ready = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_tag_head == c_TAG_W'(r)) begin
                resp_valid[r] = act_out_valid && !w_fifo_empty;
                w_head_ready  = resp_ready[r];
            end
        end
    end

    assign resp_data_out = act_data_out;
    assign act_out_ready = !w_fifo_empty && w_head_ready;
    assign w_pop         = act_out_valid && act_out_ready;
    assign busy          = w_in_burst || !w_fifo_empty;

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    assign w_grant_inc = (r_grant == c_LAST_REQ) ? '0 : (r_grant + c_TAG_W'(1));

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            c_ST_IDLE: begin
                // One arbitration cycle; no beat is forwarded here.
                if (w_arb_found) begin
                    w_grant_nxt = w_arb_idx;
                    w_state_nxt = c_ST_BURST;
                end
            end
            c_ST_BURST: begin
                // Grant is held for the whole tensor; a stalled requester
                // only stalls the burst.
                if (w_push) begin
                    if (r_beat_cnt == c_LAST_BEAT) begin
                        w_beat_cnt_nxt = '0;
                        w_rr_ptr_nxt   = w_grant_inc;
                        w_state_nxt    = c_ST_IDLE;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + c_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Tag storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr[c_PTR_W-1:0]] <= r_grant;
        end
    end

`ifndef SYNTHESIS
    // A result with no outstanding tag cannot be routed; it is dropped
    // (resp_valid stays low) and flagged here.
    a_no_orphan_result : assert property (
        @(posedge clk) disable iff (rst) !(act_out_valid && w_fifo_empty)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fixed_activation_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_activation_arbiter
// Purpose  : Self-checking bench for fixed_activation_arbiter. A behavioural
//            model (burst owner, round-robin pointer, queue of in-flight
//            results) predicts every output each cycle; a queue-based model
//            of the shared unit returns results after a programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_activation_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int OW    = 18;
    localparam int BEATS = 8;
    localparam int TD    = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*DW-1:0] req_data_in;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   act_data_in;
    logic            act_valid;
    logic            act_ready;
    logic [OW-1:0]   act_data_out;
    logic            act_out_valid;
    logic            act_out_ready;
    logic [OW-1:0]   resp_data_out;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic            busy;

    always #5 clk = ~clk;

    fixed_activation_arbiter #(
        .NUM_REQ(N), .DATA_IN_0_PRECISION_0(DW), .DATA_OUT_0_PRECISION_0(OW),
        .PARALLELISM(1), .BEATS(BEATS), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_data_in(req_data_in), .req_valid(req_valid), .req_ready(req_ready),
        .act_data_in(act_data_in), .act_valid(act_valid), .act_ready(act_ready),
        .act_data_out(act_data_out), .act_out_valid(act_out_valid),
        .act_out_ready(act_out_ready), .resp_data_out(resp_data_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Requester environment
    int sent  [N];
    int quota [N];
    int got   [N];
    int salt;
    bit rnd;
    logic       act_ready_force;
    logic [N-1:0] resp_ready_force;

    // Shared-unit model: results and the cycle from which each may be offered
    int lat;
    logic [OW-1:0] uq_d [$];
    int            uq_t [$];

    // Behavioural arbiter model
    typedef struct {
        int            r;
        logic [OW-1:0] d;
    } pend_t;
    pend_t pend [$];
    bit m_burst;
    int m_grant, m_rr, m_cnt;

    // Observation logs (from DUT handshakes)
    int            acc_r [$];
    int            acc_c [$];
    logic [OW-1:0] resp_log [$];

    function automatic logic [DW-1:0] data_of(int r, int k);
        return DW'((k + 1) << 8) + DW'(r * salt);
    endfunction

    function automatic logic [OW-1:0] unit_f(logic [DW-1:0] x);
        return {2'b01, x ^ 16'h5A5A};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_burst = 1'b0;
        m_grant = 0;
        m_rr    = 0;
        m_cnt   = 0;
        pend.delete();
        uq_d.delete();
        uq_t.delete();
    endtask

    task automatic clear_logs();
        acc_r.delete();
        acc_c.delete();
        resp_log.delete();
        for (int r = 0; r < N; r++) got[r] = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance both.
    task automatic step();
        logic [N-1:0] e_req_ready, e_resp_valid;
        logic e_act_valid, e_out_ready, e_busy;
        int sz, head;
        bit full, m_push, m_pop;
        for (int r = 0; r < N; r++) begin
            req_valid[r] = (sent[r] < quota[r]);
            req_data_in[r*DW +: DW] = data_of(r, sent[r]);
        end
        act_ready     = rnd ? 1'($urandom_range(0, 1)) : act_ready_force;
        resp_ready    = rnd ? N'($urandom_range(0, (2**N) - 1)) : resp_ready_force;
        act_out_valid = (uq_d.size() > 0) && (uq_t[0] <= cyc);
        act_data_out  = act_out_valid ? uq_d[0] : '0;
        #1;
        sz   = pend.size();
        full = (sz >= TD);
        head = (sz > 0) ? pend[0].r : 0;
        e_act_valid = m_burst && req_valid[m_grant] && !full;
        e_req_ready = '0;
        if (m_burst && act_ready && !full) e_req_ready[m_grant] = 1'b1;
        e_resp_valid = '0;
        if (act_out_valid && sz > 0) e_resp_valid[head] = 1'b1;
        e_out_ready = (sz > 0) && resp_ready[head];
        e_busy      = m_burst || (sz > 0);

        chk("req_ready", req_ready, e_req_ready);
        chk("act_valid", act_valid, e_act_valid);
        chk("act_out_ready", act_out_ready, e_out_ready);
        chk("resp_valid", resp_valid, e_resp_valid);
        chk("resp_onehot0", $onehot0(resp_valid), 1);
        chk("busy", busy, e_busy);
        chk("resp_data_passthru", resp_data_out, act_data_out);
        if (e_act_valid) chk("act_data_in", act_data_in, data_of(m_grant, sent[m_grant]));
        if (e_resp_valid != '0) chk("resp_data_order", resp_data_out, pend[0].d);

        // Advance the model with its own view of the handshakes.
        m_pop  = act_out_valid && e_out_ready;
        m_push = e_act_valid && act_ready;
        if (m_pop) void'(pend.pop_front());
        if (m_burst) begin
            if (m_push) begin
                pend.push_back(pend_t'{m_grant, unit_f(data_of(m_grant, sent[m_grant]))});
                m_cnt++;
                if (m_cnt == BEATS) begin
                    m_cnt   = 0;
                    m_rr    = (m_grant + 1) % N;
                    m_burst = 1'b0;
                end
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                int idx;
                idx = (m_rr + j) % N;
                if (req_valid[idx]) begin
                    m_grant = idx;
                    m_burst = 1'b1;
                    break;
                end
            end
        end

        // Environment reacts to what the DUT actually did.
        for (int r = 0; r < N; r++) begin
            if (req_valid[r] && req_ready[r]) begin
                acc_r.push_back(r);
                acc_c.push_back(cyc);
                sent[r]++;
            end
        end
        if (act_out_valid && act_out_ready) begin
            void'(uq_d.pop_front());
            void'(uq_t.pop_front());
        end
        if (act_valid && act_ready) begin
            uq_d.push_back(unit_f(act_data_in));
            uq_t.push_back(cyc + 1 + lat);
        end
        for (int r = 0; r < N; r++) begin
            if (resp_valid[r] && resp_ready[r]) begin
                got[r]++;
                resp_log.push_back(resp_data_out);
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit all_done();
        for (int r = 0; r < N; r++) if (sent[r] < quota[r]) return 1'b0;
        return (pend.size() == 0) && !m_burst && (uq_d.size() == 0);
    endfunction

    task automatic run_until_done(input string name, input int bound);
        int n;
        n = 0;
        while (!all_done()) begin
            if (n >= bound) begin
                checks++;
                errors++;
                $display("FAIL %s: timeout after %0d cycles, required completion", name, n);
                return;
            end
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, viol, n;
        req_data_in = '0; req_valid = '0; act_ready = 1'b0; act_data_out = '0;
        act_out_valid = 1'b0; resp_ready = '0;
        rnd = 1'b0; act_ready_force = 1'b1; resp_ready_force = '1; salt = 0; lat = 3;
        for (int r = 0; r < N; r++) begin sent[r] = 0; quota[r] = 0; end
        model_reset();
        clear_logs();

        // Reset values
        #1 rst = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_act_valid", act_valid, 0);
        chk("rst_act_out_ready", act_out_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_act_data_in", act_data_in, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Single requester 2, values 0x0100..0x0800, unit latency 3
        t0 = cyc;
        quota[2] = 8;
        run_until_done("single_burst", 200);
        chk("t1_beats", acc_r.size(), 8);
        if (acc_r.size() == 8) begin
            chk("t1_first_beat_latency", acc_c[0] - t0, 1);
            chk("t1_consecutive", acc_c[7] - acc_c[0], 7);
            chk("t1_owner", acc_r[7], 2);
        end
        chk("t1_results", got[2], 8);
        if (resp_log.size() == 8) begin
            chk("t1_first_result", resp_log[0], 18'h15B5A);
            chk("t1_last_result", resp_log[7], 18'h1525A);
        end

        // Pointer now past 2: requesters 1 and 3 -> 3 first, then wrap to 1
        clear_logs();
        salt = 'h11;
        quota[1] += 8; quota[3] += 8;
        run_until_done("rr_after_2", 300);
        chk("t1b_beats", acc_r.size(), 16);
        if (acc_r.size() == 16) begin
            chk("t1b_first_owner", acc_r[0], 3);
            chk("t1b_second_owner", acc_r[8], 1);
        end

        // Requesters 0 and 1 alternating bursts
        clear_logs();
        quota[0] += 16; quota[1] += 16;
        run_until_done("alternate", 400);
        chk("t2_beats", acc_r.size(), 32);
        if (acc_r.size() == 32) begin
            chk("t2_order0", acc_r[0], 0);
            chk("t2_order1", acc_r[8], 1);
            chk("t2_order2", acc_r[16], 0);
            chk("t2_order3", acc_r[24], 1);
            chk("t2_gap_a", acc_c[8] - acc_c[7], 2);
            chk("t2_gap_b", acc_c[16] - acc_c[15], 2);
            viol = 0;
            for (int i = 0; i < 32; i++) if (acc_r[i] != acc_r[(i / 8) * 8]) viol++;
            chk("t2_no_interleave", viol, 0);
        end

        // Tag FIFO full: results held back, latency-0 unit
        clear_logs();
        lat = 0;
        resp_ready_force = '0;
        quota[0] += 16;
        for (int i = 0; i < 20; i++) step();
        chk("t3_stalled_beats", acc_r.size(), 8);
        chk("t3_stalled_act_valid", act_valid, 0);
        chk("t3_stalled_req_ready", req_ready, 0);
        resp_ready_force = '1;
        run_until_done("fifo_full", 300);
        chk("t3_total_beats", acc_r.size(), 16);
        chk("t3_results", got[0], 16);

        // Random backpressure, four requesters x three bursts
        clear_logs();
        lat = 2;
        rnd = 1'b1;
        for (int r = 0; r < N; r++) quota[r] += 24;
        run_until_done("random", 4000);
        rnd = 1'b0;
        for (int r = 0; r < N; r++) chk("t4_results", got[r], 24);

        // Reset in the middle of a burst from requester 1
        clear_logs();
        lat = 1;
        quota[1] += 8;
        n = 0;
        while (acc_r.size() < 4 && n < 50) begin step(); n++; end
        chk("t5_beats_before_reset", acc_r.size(), 4);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_req_ready", req_ready, 0);
        chk("t5_async_act_valid", act_valid, 0);
        chk("t5_async_act_out_ready", act_out_ready, 0);
        chk("t5_async_resp_valid", resp_valid, 0);
        chk("t5_async_busy", busy, 0);
        req_valid = '0;
        act_out_valid = 1'b0;
        model_reset();
        for (int r = 0; r < N; r++) begin sent[r] = 0; quota[r] = 0; end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc += 2;
        clear_logs();
        quota[1] = 8; quota[3] = 8;
        run_until_done("after_reset", 300);
        chk("t5_beats_after", acc_r.size(), 16);
        if (acc_r.size() == 16) begin
            chk("t5_first_owner", acc_r[0], 1);
            chk("t5_second_owner", acc_r[8], 3);
        end
        chk("t5_results_r1", got[1], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fixed_activation_arbiter.md
Name: fixed_activation_arbiter

Overview:
- Shares one streaming fixed-point activation unit (e.g. fixed_tanh) between NUM_REQ requester streams.
- Grants the unit to one requester for a whole tensor (burst of BEATS beats) using round-robin arbitration.
- Tags every accepted beat in an in-order tag FIFO and routes each result from the unit back to the originating requester.
- Sits between layer datapaths and a single shared activation instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_IN_0_PRECISION_0, 16, input element width.
- DATA_OUT_0_PRECISION_0, 18, output element width.
- PARALLELISM, 1, elements per beat.
- BEATS, 8, beats per tensor burst (TENSOR_SIZE/PARALLELISM).
- TAG_DEPTH, 8, tag FIFO depth. Must be a power of 2 and ≥ the unit latency + 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_data_in  in  NUM_REQ*PARALLELISM*DATA_IN_0_PRECISION_0  per-requester input beats, requester r in slice r.
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester ready.
- act_data_in  out  PARALLELISM*DATA_IN_0_PRECISION_0  beat to the activation unit.
- act_valid  out  1  valid to the unit.
- act_ready  in  1  ready from the unit.
- act_data_out  in  PARALLELISM*DATA_OUT_0_PRECISION_0  result from the unit.
- act_out_valid  in  1  result valid.
- act_out_ready  out  1  result ready to the unit.
- resp_data_out  out  PARALLELISM*DATA_OUT_0_PRECISION_0  result broadcast to all requesters.
- resp_valid  out  NUM_REQ  one-hot result valid.
- resp_ready  in  NUM_REQ  per-requester result ready.
- busy  out  1  high in BURST or while the tag FIFO is non-empty.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, tag FIFO empty.
  - req_ready=0, act_valid=0, act_out_ready=0, resp_valid=0, busy=0.
  - Data outputs are don't-care but driven to 0.
- FSM IDLE:
  - If any req_valid is high, choose the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register it into grant and go to BURST next cycle. This is 1 cycle of arbitration overhead.
  - No beat is forwarded in IDLE.
- FSM BURST:
  - Forwarding is combinational: act_data_in = req_data_in[grant]; act_valid = req_valid[grant] && !fifo_full; req_ready[grant] = act_ready && !fifo_full; other req_ready = 0.
  - An accepted beat is act_valid && act_ready. On each accepted beat: push grant into the tag FIFO and increment beat_cnt.
  - On the accepted beat with beat_cnt==BEATS-1: beat_cnt←0, rr_ptr←(grant+1) mod NUM_REQ, state←IDLE.
  - No preemption. A requester dropping valid mid-burst only stalls the burst; grant is held.
- Return path (combinational, in-order):
  - resp_data_out = act_data_out.
  - resp_valid[tag_head] = act_out_valid && !fifo_empty; all other bits 0.
  - act_out_ready = !fifo_empty && resp_ready[tag_head].
  - Pop the FIFO on act_out_valid && act_out_ready.
- Tag FIFO:
  - Width clog2(NUM_REQ), depth TAG_DEPTH, wrapping pointers with an extra MSB for full/empty.
  - Simultaneous push and pop while full: the push is blocked, because act_valid is already gated by !fifo_full, and the pop proceeds.
  - Simultaneous push and pop while empty: legal. The pushed tag appears next cycle; a result cannot precede its input.
  - act_out_valid while the FIFO is empty is a protocol error. It is not propagated (resp_valid=0); a simulation assertion fires.
- Data is passed bit-exact; no arithmetic is performed on data.

Test Plan:
- Single requester r=2 sends 8 beats of values 0x0100..0x0800 with a unit model of latency 3 and all ready high.
  - grant=2 from cycle 2 after valid.
  - act_valid high 8 consecutive cycles.
  - resp_valid[2] one-hot for 8 results in order.
  - Then state=IDLE and rr_ptr=3.
- Requesters 0 and 1 both valid from reset release.
  - Bursts are granted in order 0, 1, 0, 1.
  - Exactly 1 idle arbitration cycle between bursts.
  - No beat interleaving on act_data_in.
- TAG_DEPTH=8, act_out_ready forced low by resp_ready=0 with a unit of latency 0.
  - After 8 accepted beats, act_valid=0 and req_ready=0.
  - Releasing resp_ready resumes the burst with no beat lost or duplicated.
- Random act_ready and resp_ready backpressure (50%) for 4 requesters × 3 bursts.
  - Each requester receives exactly 24 results.
  - Results match the scoreboard in order; resp_valid is always one-hot or zero.
- Reset asserted mid-burst (beat 4 of requester 1).
  - All valid and ready outputs drop to 0 in the same cycle, without waiting for clk.
  - After release: FIFO empty, rr_ptr=0, and a new burst from requester 1 starts at beat 0.
